loteria_entrada: RTL and testbench
==================================

// Module: loteria_entrada
// PURPOSE
// - Ticket-entry stage directly upstream of the lottery checker. Captures one ticket of
//   DIGITOS decimal digits from keypad strobes, then replays it to the checker as a
//   burst of numero/insere beats followed by a fim pulse.
// - Counts submitted tickets and raises fim_jogo once MAX_JOGOS tickets have been sent.
// PARAMETERS
// - DIGITOS    5  digits per ticket (1..7)
// - MAX_JOGOS  5  tickets per game (1..7)
// - DIG_W      4  digit width in bits (BCD)
// PORTS
// - clock        in   1      single clock; all logic on posedge
// - reset_n      in   1      asynchronous, active-low reset
// - tecla        in   DIG_W  keypad digit, sampled only while tecla_valida=1
// - tecla_valida in   1      one-cycle strobe: a key was pressed (synchronous, pre-debounced)
// - confirma     in   1      one-cycle strobe: submit the current ticket
// - apaga        in   1      one-cycle strobe: discard the digits entered so far
// - numero       out  DIG_W  digit presented to the checker
// - insere       out  1      numero valid this cycle (one digit per cycle)
// - fim          out  1      one-cycle pulse: ticket burst complete
// - fim_jogo     out  1      level: game over (MAX_JOGOS tickets sent)
// - ocupado      out  1      1 in ENVIA/FIM_BILHETE/ENCERRADO
// - erro         out  1      one-cycle pulse: an input was rejected
// - buf_cnt      out  3      digits currently held (0..DIGITOS)
// - jogos        out  3      tickets sent (0..MAX_JOGOS)
// BEHAVIOUR
// - Reset (async, reset_n=0): state=COLETA; buf_cnt=0; jogos=0; idx=0.
//   Output values during and after reset: numero=0, insere=0, fim=0, fim_jogo=0,
//   ocupado=0, erro=0. The digit buffer contents are don't-care.
// - Outputs are Moore outputs of registered state/idx; erro is a registered pulse.
// - FSM states: COLETA, ENVIA, FIM_BILHETE, ENCERRADO.
// - COLETA, per cycle, priority apaga > confirma > tecla_valida. The lower-priority
//   strobes in the same cycle are dropped without raising erro.
//   - apaga: buf_cnt <= 0.
//   - confirma with buf_cnt==DIGITOS: idx <= 0; next state ENVIA.
//   - confirma with buf_cnt<DIGITOS: erro; stay in COLETA.
//   - tecla_valida, tecla<=9, buf_cnt<DIGITOS: buf[buf_cnt] <= tecla; buf_cnt++.
//   - tecla_valida with tecla>9 or buf_cnt==DIGITOS: erro; buffer unchanged.
// - ENVIA: insere=1 and numero=buf[idx]; idx++ each cycle. After idx==DIGITOS-1 the
//   next state is FIM_BILHETE. Latency: if confirma is sampled at edge k, insere is high
//   for cycles k+1..k+DIGITOS and digits go out in entry order.
// - FIM_BILHETE (one cycle): fim=1; jogos++; buf_cnt <= 0.
//   Next state is ENCERRADO if the new jogos==MAX_JOGOS, else COLETA.
// - ENCERRADO: fim_jogo=1 (held). The state is left only by reset.
// - In ENVIA, FIM_BILHETE and ENCERRADO, any tecla_valida/confirma pulses erro and is
//   ignored; apaga is ignored silently.
// - When insere=0, numero=0, so the checker never sees stale digits.
// - Reset asserted mid-burst: the burst aborts immediately and insere/fim drop
//   asynchronously. No partial fim is issued and jogos returns to 0.
// - Counter widths: 3 bits. No wrap is possible because the saturation points are
//   reached only via the FSM.
// STRUCTURE
// - loteria_pkg holds:
//   - typedef enum estado_entrada_t {COLETA, ENVIA, FIM_BILHETE, ENCERRADO};
//   - localparam DIG_MAX = 9;
//   - the default DIGITOS and MAX_JOGOS values, shared with the checker.
// - Sub-module loteria_buffer_digitos: DIGITOS x DIG_W register file.
//   - Write port: we, waddr, wdata. Read port: raddr, combinational.
//   - The top level holds the FSM, buf_cnt, idx, jogos and the output logic.
// TESTING
// - Keys 5,3,8,2,0 then confirma -> insere for 5 cycles, numero 5,3,8,2,0; then fim=1
//   for 1 cycle; jogos=1.
// - Keys 5,3,confirma -> erro=1 for 1 cycle, ocupado=0, buf_cnt stays 2;
//   apaga -> buf_cnt=0.
// - Key tecla=4'hA -> erro pulse, buf_cnt unchanged.
//   Sixth digit on a full buffer -> erro pulse, buffer holds first 5.
// - Same-cycle apaga+confirma with a full buffer -> buf_cnt=0, no burst, no erro.
// - 5 full tickets back to back -> fim pulses 5 times and jogos=5. fim_jogo rises the
//   cycle after the 5th fim and stays 1. A 6th confirma -> erro, no insere.
// - reset_n=0 during the 3rd beat of a burst -> insere=0 at once, fim never pulses;
//   after release buf_cnt=0, jogos=0, state COLETA.

Source files
------------

// File: rtl/loteria_pkg.sv
// Shared types and default sizes for the lottery ticket entry and checker blocks.
package loteria_pkg;

  typedef enum logic [1:0] {
    COLETA      = 2'd0,
    ENVIA       = 2'd1,
    FIM_BILHETE = 2'd2,
    ENCERRADO   = 2'd3
  } estado_entrada_t;

  localparam int DIG_MAX          = 9;
  localparam int DIGITOS_PADRAO   = 5;
  localparam int MAX_JOGOS_PADRAO = 5;
  localparam int DIG_W_PADRAO     = 4;
  localparam int CNT_W            = 3;

endpackage

// File: rtl/loteria_buffer_digitos.sv
// Purpose: DIGITOS x DIG_W digit register file, one write port, one read port.
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none, the writer owns the address space.
module loteria_buffer_digitos
  import loteria_pkg::*;
#(
  parameter int DIGITOS = DIGITOS_PADRAO,
  parameter int DIG_W   = DIG_W_PADRAO
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_waddr,
  input  logic [DIG_W-1:0] i_wdata,
  input  logic [CNT_W-1:0] i_raddr,
  output logic [DIG_W-1:0] o_rdata
);

  logic [DIG_W-1:0] r_mem [DIGITOS];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/loteria_entrada.sv
// Purpose: collects one keypad ticket and replays it to the checker as insere beats plus a fim pulse.
// Latency: confirma at edge k gives insere on cycles k+1..k+DIGITOS, fim on the following cycle.
// Backpressure: none; strobes arriving while busy or invalid are dropped and flagged on erro.
module loteria_entrada
  import loteria_pkg::*;
#(
  parameter int DIGITOS   = DIGITOS_PADRAO,
  parameter int MAX_JOGOS = MAX_JOGOS_PADRAO,
  parameter int DIG_W     = DIG_W_PADRAO
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DIG_W-1:0] tecla,
  input  logic             tecla_valida,
  input  logic             confirma,
  input  logic             apaga,
  output logic [DIG_W-1:0] numero,
  output logic             insere,
  output logic             fim,
  output logic             fim_jogo,
  output logic             ocupado,
  output logic             erro,
  output logic [2:0]       buf_cnt,
  output logic [2:0]       jogos
);

  localparam logic [CNT_W-1:0] CNT_CHEIO = CNT_W'(DIGITOS);
  localparam logic [CNT_W-1:0] IDX_ULT   = CNT_W'(DIGITOS - 1);
  localparam logic [CNT_W-1:0] JOGOS_FIM = CNT_W'(MAX_JOGOS);

  estado_entrada_t  r_estado, w_estado_prox;
  logic [CNT_W-1:0] r_buf_cnt, w_buf_cnt_prox;
  logic [CNT_W-1:0] r_idx, w_idx_prox;
  logic [CNT_W-1:0] r_jogos, w_jogos_prox;
  logic             r_erro, w_erro_prox;
  logic             w_we;
  logic             w_tecla_ok;
  logic [DIG_W-1:0] w_rdata;

  loteria_buffer_digitos #(
    .DIGITOS (DIGITOS),
    .DIG_W   (DIG_W)
  ) u_buffer (
    .i_clock (clock),
    .i_we    (w_we),
    .i_waddr (r_buf_cnt),
    .i_wdata (tecla),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  assign w_tecla_ok = (tecla <= DIG_W'(DIG_MAX));

  always_comb begin
    w_estado_prox  = r_estado;
    w_buf_cnt_prox = r_buf_cnt;
    w_idx_prox     = r_idx;
    w_jogos_prox   = r_jogos;
    w_erro_prox    = 1'b0;
    w_we           = 1'b0;
    case (r_estado)
      COLETA: begin
        // apaga > confirma > tecla_valida; losers are dropped without erro.
        if (apaga) begin
          w_buf_cnt_prox = '0;
        end else if (confirma) begin
          if (r_buf_cnt == CNT_CHEIO) begin
            w_idx_prox    = '0;
            w_estado_prox = ENVIA;
          end else begin
            w_erro_prox = 1'b1;
          end
        end else if (tecla_valida) begin
          if (w_tecla_ok && (r_buf_cnt != CNT_CHEIO)) begin
            w_we           = 1'b1;
            w_buf_cnt_prox = r_buf_cnt + 1'b1;
          end else begin
            w_erro_prox = 1'b1;
          end
        end
      end
      ENVIA: begin
        w_erro_prox = tecla_valida | confirma;
        if (r_idx == IDX_ULT) begin
          w_idx_prox    = '0;
          w_estado_prox = FIM_BILHETE;
        end else begin
          w_idx_prox = r_idx + 1'b1;
        end
      end
      FIM_BILHETE: begin
        w_erro_prox    = tecla_valida | confirma;
        w_jogos_prox   = r_jogos + 1'b1;
        w_buf_cnt_prox = '0;
        w_estado_prox  = (w_jogos_prox == JOGOS_FIM) ? ENCERRADO : COLETA;
      end
      ENCERRADO: begin
        w_erro_prox = tecla_valida | confirma;
      end
      default: begin
        w_estado_prox = COLETA;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado  <= COLETA;
      r_buf_cnt <= '0;
      r_idx     <= '0;
      r_jogos   <= '0;
      r_erro    <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_buf_cnt <= w_buf_cnt_prox;
      r_idx     <= w_idx_prox;
      r_jogos   <= w_jogos_prox;
      r_erro    <= w_erro_prox;
    end
  end

  // Decoded from registered state only, so an async reset kills a burst immediately.
  assign insere   = (r_estado == ENVIA);
  assign numero   = insere ? w_rdata : '0;
  assign fim      = (r_estado == FIM_BILHETE);
  assign fim_jogo = (r_estado == ENCERRADO);
  assign ocupado  = (r_estado != COLETA);
  assign erro     = r_erro;
  assign buf_cnt  = r_buf_cnt;
  assign jogos    = r_jogos;

endmodule

// File: tb/tb_loteria_entrada.sv
// Bench for loteria_entrada: directed scenarios plus random strobes against a queue-based ticket model.
module tb_loteria_entrada;

  localparam int DIGITOS   = 5;
  localparam int MAX_JOGOS = 5;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] tecla;
  logic       tecla_valida, confirma, apaga;
  logic [3:0] numero;
  logic       insere, fim, fim_jogo, ocupado, erro;
  logic [2:0] buf_cnt, jogos;

  int n_testes = 0;
  int n_falhas = 0;

  loteria_entrada dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .confirma     (confirma),
    .apaga        (apaga),
    .numero       (numero),
    .insere       (insere),
    .fim          (fim),
    .fim_jogo     (fim_jogo),
    .ocupado      (ocupado),
    .erro         (erro),
    .buf_cnt      (buf_cnt),
    .jogos        (jogos)
  );

  always #5 clock = ~clock;

  // Model: digits typed so far, plus the queue of output beats still owed to the checker.
  typedef struct {
    bit ins;
    int num;
    bit fim;
  } beat_t;

  int    q_dig[$];
  beat_t q_saida[$];
  int    m_jogos;
  bit    m_fim_jogo;
  bit    m_erro;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_reset();
    q_dig.delete();
    q_saida.delete();
    m_jogos    = 0;
    m_fim_jogo = 0;
    m_erro     = 0;
  endtask

  task automatic modelo_borda(input bit tv, input int t, input bit c, input bit a);
    bit    ocup;
    beat_t b;
    ocup   = (q_saida.size() > 0) || m_fim_jogo;
    m_erro = 0;
    if (q_saida.size() > 0) begin
      b = q_saida.pop_front();
      if (b.fim) begin
        m_jogos++;
        q_dig.delete();
        if (m_jogos == MAX_JOGOS) m_fim_jogo = 1;
      end
    end
    if (ocup) begin
      m_erro = tv || c;
    end else if (a) begin
      q_dig.delete();
    end else if (c) begin
      if (q_dig.size() == DIGITOS) begin
        foreach (q_dig[i]) begin
          b.ins = 1; b.num = q_dig[i]; b.fim = 0;
          q_saida.push_back(b);
        end
        b.ins = 0; b.num = 0; b.fim = 1;
        q_saida.push_back(b);
      end else begin
        m_erro = 1;
      end
    end else if (tv) begin
      if (t <= 9 && q_dig.size() < DIGITOS) q_dig.push_back(t);
      else m_erro = 1;
    end
  endtask

  task automatic confere_saidas(input string ctx);
    beat_t h;
    h.ins = 0; h.num = 0; h.fim = 0;
    if (q_saida.size() > 0) h = q_saida[0];
    verifica({ctx, ".insere"},   32'(insere),   32'(h.ins));
    verifica({ctx, ".numero"},   32'(numero),   h.num);
    verifica({ctx, ".fim"},      32'(fim),      32'(h.fim));
    verifica({ctx, ".fim_jogo"}, 32'(fim_jogo), 32'(m_fim_jogo));
    verifica({ctx, ".ocupado"},  32'(ocupado),  32'((q_saida.size() > 0) || m_fim_jogo));
    verifica({ctx, ".erro"},     32'(erro),     32'(m_erro));
    verifica({ctx, ".buf_cnt"},  32'(buf_cnt),  q_dig.size());
    verifica({ctx, ".jogos"},    32'(jogos),    m_jogos);
  endtask

  task automatic ciclo(input string ctx, input bit tv, input int t, input bit c, input bit a);
    tecla_valida = tv;
    tecla        = t[3:0];
    confirma     = c;
    apaga        = a;
    @(posedge clock);
    #1;
    modelo_borda(tv, t, c, a);
    tecla_valida = 0;
    confirma     = 0;
    apaga        = 0;
    confere_saidas(ctx);
  endtask

  task automatic aplica_reset();
    reset_n = 1'b0;
    #3;
    modelo_reset();
    confere_saidas("reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic ciclo_rand(input string ctx);
    ciclo(ctx, ($urandom % 3) == 0, $urandom_range(0, 11),
          ($urandom % 8) == 0, ($urandom % 25) == 0);
  endtask

  initial begin
    int t1[5];
    int got[$];
    t1[0] = 5; t1[1] = 3; t1[2] = 8; t1[3] = 2; t1[4] = 0;
    tecla = 0; tecla_valida = 0; confirma = 0; apaga = 0;
    aplica_reset();

    // First ticket 5,3,8,2,0: the digits reaching the checker are checked against constants too.
    foreach (t1[i]) ciclo("t1_tecla", 1, t1[i], 0, 0);
    ciclo("t1_confirma", 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (insere) got.push_back(int'(numero));
      ciclo("t1_burst", 0, 0, 0, 0);
    end
    verifica("t1_n_digitos", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) verifica("t1_digito", got[i], t1[i]);
    verifica("t1_jogos", 32'(jogos), 1);

    // Early confirma, then apaga.
    ciclo("curto_tecla", 1, 5, 0, 0);
    ciclo("curto_tecla", 1, 3, 0, 0);
    ciclo("curto_confirma", 0, 0, 1, 0);
    verifica("curto_erro", 32'(erro), 1);
    verifica("curto_buf_cnt", 32'(buf_cnt), 2);
    ciclo("curto_pos", 0, 0, 0, 0);
    ciclo("curto_apaga", 0, 0, 0, 1);
    verifica("apaga_buf_cnt", 32'(buf_cnt), 0);

    // Non-decimal key, then a sixth key on a full buffer, then send it.
    ciclo("tecla_A", 1, 10, 0, 0);
    for (int i = 1; i <= 6; i++) ciclo("cheio_tecla", 1, i, 0, 0);
    verifica("sexta_tecla_erro", 32'(erro), 1);
    ciclo("t2_confirma", 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) ciclo("t2_burst", 0, 0, 0, 0);

    // apaga and confirma together on a full buffer.
    for (int i = 0; i < 5; i++) ciclo("ac_tecla", 1, 9 - i, 0, 0);
    ciclo("apaga_confirma", 0, 0, 1, 1);
    verifica("ac_sem_burst", 32'(insere), 0);
    for (int i = 0; i < 3; i++) ciclo("ac_pos", 0, 0, 0, 0);

    // Random strobes until the game closes.
    for (int i = 0; i < 3000 && !m_fim_jogo; i++) ciclo_rand("rand");
    verifica("fim_jogo_alcancado", 32'(fim_jogo), 1);
    ciclo("sexto_confirma", 0, 0, 1, 0);
    verifica("sexto_confirma_erro", 32'(erro), 1);
    for (int i = 0; i < 40; i++) ciclo_rand("encerrado");

    // Reset during the third beat of a burst.
    aplica_reset();
    foreach (t1[i]) ciclo("rst_tecla", 1, t1[i], 0, 0);
    ciclo("rst_confirma", 0, 0, 1, 0);
    ciclo("rst_beat", 0, 0, 0, 0);
    ciclo("rst_beat", 0, 0, 0, 0);
    verifica("beat3_insere", 32'(insere), 1);
    verifica("beat3_numero", 32'(numero), t1[2]);
    #2 reset_n = 1'b0;
    #1;
    verifica("rst_async_insere", 32'(insere), 0);
    verifica("rst_async_fim", 32'(fim), 0);
    verifica("rst_async_jogos", 32'(jogos), 0);
    verifica("rst_async_buf_cnt", 32'(buf_cnt), 0);
    modelo_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) ciclo("pos_rst", 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) ciclo_rand("rand2");

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
